bmf_stream_decoder: RTL and testbench

- Streaming Boolean-matrix-factorization decompressor: expands K-bit latent codes from a BMF compressor stage into M-bit reconstructed output words.
- Each output bit is the Boolean (OR-of-AND) product of the code with a programmable K x M basis matrix H.
- Sits downstream of the latent-code producer; a valid/ready stream on both sides, with a side configuration port for loading H rows.
- Registered, full-throughput pipeline with a skid buffer, so in_ready is driven from a register.

---
 rtl/bmf_stream_decoder.sv | 107 ++++++++++
 tb/tb_bmf_stream_decoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bmf_stream_decoder.sv
// Streaming Boolean-matrix-factorization decompressor.
// Each K-bit latent code becomes an M-bit word. Every output bit is the
// OR-of-AND product of the code with a programmable K x M basis matrix.
// The pipeline is registered and runs at full throughput. A one-entry skid
// register holds a word under backpressure, so in_ready comes from a flop.
module bmf_stream_decoder #(
  parameter int K  = 3,
  parameter int M  = 4,
  parameter int CW = 16,
  localparam int RW = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [K-1:0]  in_code,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_data,
  input  logic          cfg_we,
  input  logic [RW-1:0] cfg_row,
  input  logic [M-1:0]  cfg_data,
  output logic          cfg_err,
  output logic [CW-1:0] out_count
);

  // K widened by one bit so that cfg_row can be range-checked without truncation
  localparam logic [RW:0] KV = (RW+1)'(K);

  logic [M-1:0] h [K];
  logic [M-1:0] word;
  logic         or_valid;
  logic [M-1:0] or_data;
  logic         sk_full;
  logic [M-1:0] sk_data;
  logic         accept;
  logic         handoff;

  assign accept    = in_valid & in_ready;
  assign handoff   = ~or_valid | out_ready;
  assign in_ready  = ~sk_full;
  assign out_valid = or_valid;
  assign out_data  = or_data;

  // Boolean product of the incoming code with the current basis (pre-write H)
  always_comb begin
    word = '0;
    for (int i = 0; i < K; i++) begin
      if (in_code[i]) word = word | h[i];
    end
  end

  // Output register and skid register; moves data so strict FIFO order is kept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      or_valid <= 1'b0;
      or_data  <= '0;
      sk_full  <= 1'b0;
      sk_data  <= '0;
    end else if (handoff) begin
      if (sk_full) begin
        or_valid <= 1'b1;
        or_data  <= sk_data;
        sk_full  <= accept;
        if (accept) sk_data <= word;
      end else begin
        or_valid <= accept;
        if (accept) or_data <= word;
      end
    end else if (accept) begin
      sk_full <= 1'b1;
      sk_data <= word;
    end
  end

  // Basis matrix: shifted-identity default, row writes apply from the next edge on
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) begin
        h[i] <= M'(1) << (i + 1);
      end
    end else begin
      for (int i = 0; i < K; i++) begin
        if (cfg_we && (cfg_row == RW'(i))) h[i] <= cfg_data;
      end
    end
  end

  // Sticky flag for writes addressed past the last basis row
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else if (cfg_we && ({1'b0, cfg_row} >= KV)) begin
      cfg_err <= 1'b1;
    end
  end

  // Wrapping count of words delivered downstream
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_count <= '0;
    end else if (or_valid && out_ready) begin
      out_count <= out_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_bmf_stream_decoder.sv
// Self-checking bench for bmf_stream_decoder (K=3, M=4, CW=4).
module tb_bmf_stream_decoder;

  localparam int K  = 3;
  localparam int M  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [K-1:0]  in_code;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out_data;
  logic          cfg_we;
  logic [1:0]    cfg_row;
  logic [M-1:0]  cfg_data;
  logic          cfg_err;
  logic [CW-1:0] out_count;

  logic [M-1:0] mh [K];
  logic [M-1:0] sbq [$];
  int           exp_count;
  int           n_compared;
  int           n_mismatched;

  bmf_stream_decoder #(.K(K), .M(M), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_row   (cfg_row),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [M-1:0] refWord(input logic [K-1:0] code);
    logic [M-1:0] w;
    w = '0;
    for (int i = 0; i < K; i++) begin
      if (code[i]) w = w | mh[i];
    end
    return w;
  endfunction

  task automatic modelReset();
    mh[0] = 4'b0010;
    mh[1] = 4'b0100;
    mh[2] = 4'b1000;
    sbq.delete();
    exp_count = 0;
  endtask

  // Updates the scoreboard from the handshakes about to happen, then advances one edge
  task automatic step();
    logic [M-1:0] w;
    if (!rst_n) begin
      modelReset();
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checkOutput("sb_unexpected_word", sbq.size(), 1);
        end else begin
          w = sbq.pop_front();
          checkOutput("sb_order", out_data, w);
        end
        exp_count++;
      end
      if (in_valid && in_ready) sbq.push_back(refWord(in_code));
      if (cfg_we && cfg_row < 2'd3) mh[cfg_row] = cfg_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [K-1:0] code, input logic ordy,
                               input logic we, input logic [1:0] row, input logic [M-1:0] data);
    in_valid  = iv;
    in_code   = code;
    out_ready = ordy;
    cfg_we    = we;
    cfg_row   = row;
    cfg_data  = data;
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    modelReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 4'h0);
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 4'h0);

    // Reset state
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready",  in_ready,  1);
    checkOutput("rst_out_data",  out_data,  0);
    checkOutput("rst_cfg_err",   cfg_err,   0);
    checkOutput("rst_out_count", out_count, 0);
    rst_n = 1'b1;

    // Default basis streaming
    applyStimulus(1'b1, 3'b001, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("def_001_valid", out_valid, 1);
    checkOutput("def_001", out_data, 4'b0010);
    applyStimulus(1'b1, 3'b010, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("def_010", out_data, 4'b0100);
    applyStimulus(1'b1, 3'b100, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("def_100", out_data, 4'b1000);
    applyStimulus(1'b1, 3'b111, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("def_111", out_data, 4'b1110);
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("def_idle_valid", out_valid, 0);
    checkOutput("def_count", out_count, 4);

    // Backpressure fills the skid register
    applyStimulus(1'b1, 3'b001, 1'b0, 1'b0, 2'd0, 4'h0);
    checkOutput("bp_first_data", out_data, 4'b0010);
    checkOutput("bp_first_ready", in_ready, 1);
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 2'd0, 4'h0);
    checkOutput("bp_skid_ready", in_ready, 0);
    checkOutput("bp_hold_data", out_data, 4'b0010);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 4'h0);
    checkOutput("bp_stable_data", out_data, 4'b0010);
    checkOutput("bp_stable_valid", out_valid, 1);
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("bp_second_data", out_data, 4'b0100);
    checkOutput("bp_ready_back", in_ready, 1);
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("bp_drained", out_valid, 0);
    checkOutput("bp_count", out_count, 6);

    // Reprogramming: a write in the accept cycle does not affect that word
    applyStimulus(1'b1, 3'b001, 1'b1, 1'b1, 2'd0, 4'b1011);
    checkOutput("cfg_same_cycle", out_data, 4'b0010);
    applyStimulus(1'b1, 3'b001, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("cfg_new_row0", out_data, 4'b1011);
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b1, 2'd1, 4'b0110);
    applyStimulus(1'b1, 3'b011, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("cfg_overlap", out_data, 4'b1111);
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("cfg_count", out_count, 9);

    // Out-of-range row write: flag only, basis and stream untouched
    applyStimulus(1'b1, 3'b100, 1'b1, 1'b1, 2'd3, 4'b1111);
    checkOutput("bad_stream", out_data, 4'b1000);
    checkOutput("bad_err_set", cfg_err, 1);
    applyStimulus(1'b1, 3'b001, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("bad_row0_kept", out_data, 4'b1011);
    checkOutput("bad_err_sticky", cfg_err, 1);
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("bad_count", out_count, 11);

    // Reset with both registers full
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 2'd0, 4'h0);
    applyStimulus(1'b1, 3'b100, 1'b0, 1'b0, 2'd0, 4'h0);
    checkOutput("mid_full", in_ready, 0);
    rst_n = 1'b0;
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 4'h0);
    checkOutput("mid_out_valid", out_valid, 0);
    checkOutput("mid_in_ready",  in_ready,  1);
    checkOutput("mid_cfg_err",   cfg_err,   0);
    checkOutput("mid_out_count", out_count, 0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'b001, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("mid_default_h", out_data, 4'b0010);

    // Counter wrap: 17 words delivered since reset
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 3'b010, 1'b1, 1'b0, 2'd0, 4'h0);
    end
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("wrap_count", out_count, 1);

    // Random traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 10; i++) begin
      if (sbq.size() != 0 || out_valid) applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 4'h0);
    end
    checkOutput("rnd_drain_queue", sbq.size(), 0);
    checkOutput("rnd_drain_valid", out_valid, 0);
    checkOutput("rnd_count", out_count, exp_count % 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
